inst_fetch: RTL

Fetch stage of the multi-cycle CPU. Sits directly upstream of the instruction memory and holds the program counter. Drives the memory byte address and read strobe, and latches the returned big-endian word into the instruction register (IR). Computes the next PC, splits IR into fields for the decoder and control unit, and runs a RUN/HALT/FAULT state machine that freezes fetch on a halt opcode or an illegal target address.

---
 rtl/inst_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Fetch stage: PC, instruction register and next-PC selection,
// with a RUN/HALT/FAULT machine that freezes fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 301,
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Imm32,
  input  logic [31:0] JrAddr,
  input  logic [31:0] IDataOut,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] IR,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] addr26,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic [31:0] InstCount
);

  // Last byte address at which a whole word still fits.
  localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_fault_addr;
  logic [31:0] r_count;

  logic [31:0] w_pc4;
  logic [31:0] w_next;
  logic        w_legal;
  logic        w_run;
  logic        w_bad_jump;
  logic        w_halt_op;

  assign w_pc4 = r_pc + 32'd4;

  // Next-PC mux; the jump form uses the latched IR, not the bus.
  always_comb begin
    w_next = w_pc4;
    unique case (PCSrc)
      2'b00: w_next = w_pc4;
      2'b01: w_next = w_pc4 + {Imm32[29:0], 2'b00};
      2'b10: w_next = {w_pc4[31:28], r_ir[25:0], 2'b00};
      2'b11: w_next = JrAddr;
      default: w_next = w_pc4;
    endcase
  end

  assign w_legal    = (w_next[1:0] == 2'b00) && (w_next <= LAST);
  assign w_run      = (r_state == S_RUN);
  assign w_bad_jump = w_run && PCWre && !w_legal;
  assign w_halt_op  = IDataOut[31:26] == HALT_OP;

  // PC, IR, counters and state; a bad target beats a halt opcode.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_fault_addr <= 32'd0;
      r_count      <= 32'd0;
    end else if (w_run) begin
      if (IRWre) begin
        r_ir    <= IDataOut;
        r_count <= r_count + 32'd1;
      end
      if (PCWre && w_legal)
        r_pc <= w_next;
      if (w_bad_jump) begin
        r_fault_addr <= w_next;
        r_state      <= S_FAULT;
      end else if (IRWre && w_halt_op) begin
        r_state <= S_HALT;
      end
    end
  end

  assign IAddr     = r_pc;
  assign PC        = r_pc;
  assign PC4       = w_pc4;
  assign IR        = r_ir;
  assign op        = r_ir[31:26];
  assign rs        = r_ir[25:21];
  assign rt        = r_ir[20:16];
  assign rd        = r_ir[15:11];
  assign sa        = r_ir[10:6];
  assign funct     = r_ir[5:0];
  assign imm16     = r_ir[15:0];
  assign addr26    = r_ir[25:0];
  assign RW        = w_run;
  assign Halted    = (r_state == S_HALT);
  assign Fault     = (r_state == S_FAULT);
  assign FaultAddr = r_fault_addr;
  assign InstCount = r_count;

endmodule
